// File: rtl/mips_pkg.sv
// mips_pkg
// Shared declarations for the boot-time instruction-memory loader:
//   - loader_state_e : loader FSM states
//   - IMG_HDR_BYTES  : bytes in the image header (big-endian word count)
//   - BYTES_PER_WORD : bytes per instruction word
package mips_pkg;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      CHK,
      RUN,
      ERR
   } loader_state_e;

   localparam int IMG_HDR_BYTES  = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_asm.sv
// imem_word_asm
// Assembles big-endian instruction words from a byte stream.
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset (discards any partial word)
//   byte_valid_i : byte_i is consumed this cycle
//   byte_i       : payload byte, most significant byte of each word first
//   word_valid_o : combinational, high when byte_i completes a word
//   word_o       : combinational, the completed word (valid with word_valid_o)
module imem_word_asm
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam int CNT_W   = $clog2(BYTES_PER_WORD);
   localparam int SHIFT_W = 8 * (BYTES_PER_WORD - 1);

   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      // The final byte is appended combinationally so the word is available
      // on the accepting edge of its last byte, without an extra stage.
      word_valid_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
      word_o       = {shift_q, byte_i};
      if (byte_valid_i) begin
         shift_d = {shift_q[SHIFT_W-9:0], byte_i};
         cnt_d   = cnt_q + 1'b1;   // wraps to 0 after the last byte
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot loader in front of the MIPS core. Accepts an image over a
// valid/ready byte link (count_hi, count_lo, N*4 payload bytes, checksum),
// writes the words into instruction memory and releases the core only if
// the 8-bit sum of all image bytes is zero.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   rx_data    : incoming image byte
//   rx_valid   : rx_data is valid
//   rx_ready   : loader accepts a byte (HDR_HI, HDR_LO, DATA, CHK)
//   imem_we    : one-cycle write strobe per assembled word
//   imem_addr  : word address of the write (held when imem_we=0)
//   imem_wdata : word to write (held when imem_we=0)
//   cpu_rst    : core reset, low only once the image has verified
//   load_done  : image loaded and verified (sticky until rst)
//   load_err   : size or checksum failure (sticky until rst)
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err
);

   // Capacity in words, in 17 bits so a 16-bit count can be compared
   // against it without truncation.
   localparam logic [16:0] DEPTH = 17'(1 << ADDR_W);

   loader_state_e     state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [ADDR_W:0]   widx_q, widx_d;     // one spare bit: N == DEPTH is legal
   logic [7:0]        sum_q, sum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              accept;
   logic [7:0]        sum_add;
   logic [15:0]       n_full;
   logic              asm_byte_valid;
   logic              word_valid;
   logic [31:0]       word;

   assign rx_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                     (state_q == DATA)   || (state_q == CHK);
   assign accept   = rx_valid && rx_ready;
   assign sum_add  = sum_q + rx_data;          // wraps mod 256
   assign n_full   = {count_q[15:8], rx_data}; // count as seen in HDR_LO

   assign asm_byte_valid = accept && (state_q == DATA);

   imem_word_asm u_word_asm (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (asm_byte_valid),
      .byte_i       (rx_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      widx_d  = widx_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      if (accept) begin
         sum_d = sum_add;
      end

      // Write is registered: it appears the cycle after the 4th byte's edge.
      if (word_valid) begin
         we_d    = 1'b1;
         addr_d  = widx_q[ADDR_W-1:0];
         wdata_d = word;
         widx_d  = widx_q + 1'b1;
      end

      case (state_q)
         HDR_HI: begin
            if (accept) begin
               count_d[15:8] = rx_data;
               state_d       = HDR_LO;
            end
         end
         HDR_LO: begin
            if (accept) begin
               count_d[7:0] = rx_data;
               if ({1'b0, n_full} > DEPTH) begin
                  state_d = ERR;
               end else if (n_full == 16'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (word_valid && ((17'(widx_q) + 17'd1) == {1'b0, count_q})) begin
               state_d = CHK;
            end
         end
         CHK: begin
            if (accept) begin
               state_d = (sum_add == 8'd0) ? RUN : ERR;
            end
         end
         RUN:     state_d = RUN;
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HDR_HI;
         count_q <= '0;
         widx_q  <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         widx_q  <= widx_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rst    = (state_q != RUN);
   assign load_done  = (state_q == RUN);
   assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader (ADDR_W=2, capacity 4 words):
// a table of hand-computed images, hand-written latency/reset sequences,
// and random images compared against a byte-level image parser model.
module tb_imem_loader;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   typedef logic [7:0] bq_t [$];

   typedef struct {
      logic [159:0] stream;   // image bytes, right-justified, first byte highest
      int           n;
      int           exp_nwr;
      logic [31:0]  exp_last;
      bit           exp_done;
      bit           exp_err;
      int           exp_acc;
      bit           gaps;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst;
   logic          load_done;
   logic          load_err;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] wr_addr [$];
   logic [31:0]   wr_data [$];

   logic [31:0]   exp_words [$];
   bit            exp_done;
   bit            exp_err;
   int            exp_acc;

   vec_t vec [8];

   imem_loader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   // Write log, sampled away from the active edge.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " rst rx_ready"},   32'(rx_ready),  32'd1);
      chk({tag, " rst imem_we"},    32'(imem_we),   32'd0);
      chk({tag, " rst imem_addr"},  32'(imem_addr), 32'd0);
      chk({tag, " rst imem_wdata"}, imem_wdata,     32'd0);
      chk({tag, " rst cpu_rst"},    32'(cpu_rst),   32'd1);
      chk({tag, " rst load_done"},  32'(load_done), 32'd0);
      chk({tag, " rst load_err"},   32'(load_err),  32'd0);
   endtask

   task automatic drive_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Offers each byte in turn, optionally with idle gaps; stops when the
   // loader refuses a byte. Returns the number of bytes accepted.
   task automatic send_stream(input bq_t s, input bit gaps, output int nacc);
      logic rdy;
      nacc = 0;
      for (int i = 0; i < s.size(); i++) begin
         if (gaps) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin
               rx_valid = 1'b0;
               @(negedge clk);
            end
         end
         rx_valid = 1'b1;
         rx_data  = s[i];
         rdy      = rx_ready;
         @(negedge clk);
         if (!rdy) break;
         nacc++;
      end
      rx_valid = 1'b0;
   endtask

   // Image parser model: header count, payload words, mod-256 checksum.
   task automatic model(input bq_t s);
      int         n;
      int         need;
      logic [7:0] sum;
      exp_words.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      n = int'({s[0], s[1]});
      if (n > DEPTH) begin
         exp_err = 1'b1;
         exp_acc = 2;
         return;
      end
      need = 2 + 4 * n + 1;
      for (int i = 0; i < n; i++)
         exp_words.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      sum = 8'h00;
      for (int j = 0; j < need; j++) sum = sum + s[j];
      exp_done = (sum == 8'h00);
      exp_err  = !exp_done;
      exp_acc  = need;
   endtask

   task automatic check_result(input string tag, input int nacc);
      int m;
      repeat (3) @(negedge clk);
      chk({tag, " accepted"}, 32'(nacc), 32'(exp_acc));
      chk({tag, " nwrites"},  32'(wr_data.size()), 32'(exp_words.size()));
      m = (wr_data.size() < exp_words.size()) ? wr_data.size() : exp_words.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s wr%0d addr", tag, i), 32'(wr_addr[i]), 32'(i));
         chk($sformatf("%s wr%0d data", tag, i), wr_data[i], exp_words[i]);
      end
      chk({tag, " load_done"}, 32'(load_done), 32'(exp_done));
      chk({tag, " load_err"},  32'(load_err),  32'(exp_err));
      chk({tag, " cpu_rst"},   32'(cpu_rst),   32'(!exp_done));
      chk({tag, " rx_ready"},  32'(rx_ready),  32'd0);
      chk({tag, " imem_we idle"}, 32'(imem_we), 32'd0);
      if (wr_data.size() > 0) begin
         chk({tag, " addr hold"},  32'(imem_addr), 32'(wr_addr[wr_addr.size()-1]));
         chk({tag, " wdata hold"}, imem_wdata, wr_data[wr_data.size()-1]);
      end
   endtask

   initial begin
      bq_t        q;
      int         nacc;
      string      tag;

      vec[0] = '{160'h00012008_0005D2, 7, 1, 32'h20080005, 1'b1, 1'b0, 7, 1'b0};
      vec[1] = '{160'h00012008_000500, 7, 1, 32'h20080005, 1'b0, 1'b1, 7, 1'b1};
      vec[2] = '{160'h00000077, 4, 0, 32'h0, 1'b1, 1'b0, 3, 1'b0};
      vec[3] = '{160'h00051234, 4, 0, 32'h0, 1'b0, 1'b1, 2, 1'b0};
      vec[4] = '{160'h0004_11111111_22222222_33333333_44444444_54, 19, 4, 32'h44444444, 1'b1, 1'b0, 19, 1'b1};
      vec[5] = '{160'h0100FF, 3, 0, 32'h0, 1'b0, 1'b1, 2, 1'b1};
      vec[6] = '{160'h0002_01020304_A0B0C0D0_14, 11, 2, 32'hA0B0C0D0, 1'b1, 1'b0, 11, 1'b1};
      vec[7] = '{160'h0002_01020304_A0B0C0D0_15, 11, 2, 32'hA0B0C0D0, 1'b0, 1'b1, 11, 1'b0};

      do_reset(2);
      check_reset_state("init");

      // Table-driven images.
      for (int v = 0; v < 8; v++) begin
         tag = $sformatf("vec%0d", v);
         q.delete();
         for (int i = 0; i < vec[v].n; i++)
            q.push_back(vec[v].stream[8*(vec[v].n-1-i) +: 8]);
         do_reset(2);
         check_reset_state(tag);
         wr_addr.delete();
         wr_data.delete();
         send_stream(q, vec[v].gaps, nacc);
         model(q);
         check_result(tag, nacc);
         chk({tag, " tbl nwr"},  32'(wr_data.size()), 32'(vec[v].exp_nwr));
         chk({tag, " tbl done"}, 32'(load_done), 32'(vec[v].exp_done));
         chk({tag, " tbl err"},  32'(load_err),  32'(vec[v].exp_err));
         chk({tag, " tbl acc"},  32'(nacc),      32'(vec[v].exp_acc));
         if (vec[v].exp_nwr > 0)
            chk({tag, " tbl last"}, imem_wdata, vec[v].exp_last);
         $display("vec%0d: accepted=%0d writes=%0d done=%0b err=%0b", v, nacc, wr_data.size(), load_done, load_err);
      end

      // Cycle-exact latency on the single-word image.
      do_reset(2);
      drive_byte(8'h00); drive_byte(8'h01);
      drive_byte(8'h20); drive_byte(8'h08); drive_byte(8'h00);
      chk("lat no early we", 32'(imem_we), 32'd0);
      drive_byte(8'h05);
      chk("lat we",      32'(imem_we),   32'd1);
      chk("lat addr",    32'(imem_addr), 32'd0);
      chk("lat wdata",   imem_wdata,     32'h20080005);
      chk("lat cpu_rst held", 32'(cpu_rst), 32'd1);
      drive_byte(8'hD2);
      chk("lat we off",  32'(imem_we),   32'd0);
      chk("lat cpu_rst", 32'(cpu_rst),   32'd0);
      chk("lat done",    32'(load_done), 32'd1);
      chk("lat ready",   32'(rx_ready),  32'd0);
      chk("lat wdata hold", imem_wdata,  32'h20080005);
      $display("latency seq: cpu_rst=%0b load_done=%0b", cpu_rst, load_done);

      // Oversize header: ERR right after the second byte.
      do_reset(2);
      drive_byte(8'h00);
      drive_byte(8'h05);
      chk("ovr ready",   32'(rx_ready),  32'd0);
      chk("ovr err",     32'(load_err),  32'd1);
      chk("ovr done",    32'(load_done), 32'd0);
      chk("ovr cpu_rst", 32'(cpu_rst),   32'd1);
      chk("ovr we",      32'(imem_we),   32'd0);
      $display("oversize seq: rx_ready=%0b load_err=%0b", rx_ready, load_err);

      // Reset after two payload bytes, then a fresh one-word image.
      do_reset(2);
      drive_byte(8'h00); drive_byte(8'h01);
      drive_byte(8'h20); drive_byte(8'h08);
      do_reset(1);
      check_reset_state("midrst");
      wr_addr.delete();
      wr_data.delete();
      q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC7};
      send_stream(q, 1'b0, nacc);
      model(q);
      check_result("midrst", nacc);
      chk("midrst word", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'hDEADBEEF);
      $display("mid-reset seq: writes=%0d done=%0b", wr_data.size(), load_done);

      // Random images against the parser model.
      for (int t = 0; t < 25; t++) begin
         int         n;
         logic [7:0] sum;
         logic [7:0] b;
         n = $urandom_range(0, DEPTH + 1);
         q.delete();
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
         for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
         end
         sum = 8'h00;
         foreach (q[i]) sum = sum + q[i];
         b = 8'h00 - sum;
         if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
         q.push_back(b);
         tag = $sformatf("rnd%0d", t);
         do_reset(1 + $urandom_range(0, 1));
         wr_addr.delete();
         wr_data.delete();
         send_stream(q, 1'b1, nacc);
         model(q);
         check_result(tag, nacc);
         $display("rnd%0d: N=%0d accepted=%0d writes=%0d done=%0b err=%0b", t, n, nacc, wr_data.size(), load_done, load_err);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS core.
- Receives a byte stream over a valid/ready link and assembles big-endian 32-bit instruction words.
- Writes those words into the core's instruction memory and holds the core in reset until the image is complete and its checksum verifies.
- On success it releases the core; on failure it keeps the core in reset and flags an error.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx_data  in  8  incoming image byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word to write
- cpu_rst  out  1  reset to the MIPS core; high while loading
- load_done  out  1  image loaded and verified; sticky
- load_err  out  1  checksum or size error; sticky

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=HDR_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0. Internal state also clears: word count, word index, byte counter, checksum.
- rst mid-load returns the block to HDR_HI; memory contents already written are not cleared.
- Byte acceptance: a byte is accepted on a rising edge with rx_valid && rx_ready. Without acceptance nothing advances, and arbitrary gaps in rx_valid are tolerated.
- Image format, in order:
  - count_hi, count_lo: N, a 16-bit word count, big-endian.
  - N×4 payload bytes, each word MSB first.
  - One checksum byte.
- Checksum rule: the 8-bit modular sum of every accepted byte (header, payload and checksum) must equal 0x00.
- States:
  - HDR_HI: accept byte, latch count[15:8] → HDR_LO.
  - HDR_LO: accept byte, latch count[7:0], then:
    - full N > DEPTH → ERR, with no further byte accepted;
    - N == 0 → CHK;
    - otherwise → DATA.
  - DATA: shift each byte into the word register. On the 4th byte of a word, register a one-cycle write on the next cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word. The word index then increments. After word N-1's 4th byte → CHK.
  - CHK: accept byte, add to sum. Sum == 0 → RUN, otherwise → ERR.
  - RUN: rx_ready=0, cpu_rst=0, load_done=1. Stays here until rst.
  - ERR: rx_ready=0, cpu_rst=1, load_err=1. Stays here until rst.
- rx_ready is 1 only in HDR_HI, HDR_LO, DATA and CHK. It is combinational from state.
- Latency:
  - imem_we asserts exactly 1 cycle after the accepting edge of a word's 4th byte.
  - cpu_rst falls, and load_done rises, 1 cycle after the accepting edge of a valid checksum byte.
  - The last imem_we occurs no later than the cycle cpu_rst falls.
- Widths and wrap:
  - The word index is ADDR_W+1 bits wide internally.
  - N == DEPTH is legal: the last address is DEPTH-1, with no wrap.
  - The checksum wraps mod 256.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- load_done and load_err are never both 1.

Decomposition:
- Shared package (mips_pkg):
  - loader state enum: HDR_HI, HDR_LO, DATA, CHK, RUN, ERR;
  - localparam IMG_HDR_BYTES=2;
  - localparam BYTES_PER_WORD=4.
- Optional sub-module: imem_word_asm. It is a 4-byte shift register plus a 2-bit byte counter, and emits word_valid and the word. The FSM, checksum and address counter stay in imem_loader.

Test Plan:
- Single word: bytes 00 01 20 08 00 05 D2 → exactly one imem_we with addr 0, wdata 0x20080005; next cycle cpu_rst=0, load_done=1, rx_ready=0.
- Bad checksum: same stream with last byte 00 → no change to the write; after the checksum load_err=1, cpu_rst stays 1, load_done=0.
- Empty image: bytes 00 00 00 → no imem_we; load_done=1, cpu_rst=0.
- Oversize image with ADDR_W=2: header 00 05 → ERR on the cycle after the 2nd byte; rx_ready=0, no imem_we, load_err=1.
- Full capacity with gaps, ADDR_W=2: 4 words 0x11111111..0x44444444, rx_valid toggled randomly → writes to addr 0..3 in order with the correct data; load_done=1.
- Reset mid-load: assert rst for 1 cycle after 2 payload bytes, then send a valid 1-word image → one write at addr 0 with the new word; the partial word is discarded; load_done=1.
